// File: rtl/serial_tx_pkg.sv
// Shared state encoding, default parameters and counter sizing helper.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  localparam int DEF_DW        = 8;
  localparam int DEF_BAUD_DIV  = 4;
  localparam int DEF_PARITY_EN = 1;
  localparam int DEF_GAP_CYC   = 2;

  // Bits needed to count 0..range_n-1, never less than one.
  function automatic int cnt_w(input int range_n);
    return (range_n <= 2) ? 1 : $clog2(range_n);
  endfunction

endpackage

// File: rtl/serial_tx_ctrl_piso_shift.sv
// Parallel-in serial-out shift register, MSB presented first.
module piso_shift #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic          shift_i,
  output logic          msb_o
);

  logic [DW-1:0] sreg_q;

  // Load wins over shift; shifting fills zeros from the LSB side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sreg_q <= '0;
    else if (load_i)  sreg_q <= data_i;
    else if (shift_i) sreg_q <= {sreg_q[DW-2:0], 1'b0};
  end

  assign msb_o = sreg_q[DW-1];

endmodule

// File: rtl/serial_tx_ctrl.sv
// Framed serial transmitter: data bits MSB first, optional even parity,
// then a forced idle gap. Abort cancels a frame without frame_done.
module serial_tx_ctrl
  import serial_tx_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int BAUD_DIV  = DEF_BAUD_DIV,
  parameter int PARITY_EN = DEF_PARITY_EN,
  parameter int GAP_CYC   = DEF_GAP_CYC
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] data_in,
  input  logic          data_valid,
  output logic          data_ready,
  input  logic          abort,
  output logic          sout,
  output logic          busy,
  output logic          frame_done
);

  localparam int BW = cnt_w(BAUD_DIV);
  localparam int CW = cnt_w(DW);
  localparam int GW = cnt_w(GAP_CYC);

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [CW-1:0] bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          par_q, par_d;
  logic          done_q, done_d;
  logic          load, shift, msb, handshake, baud_tc;

  assign data_ready = (state_q == ST_IDLE) && !abort;
  assign handshake  = data_valid && data_ready;
  assign baud_tc    = (baud_q == BW'(BAUD_DIV - 1));

  piso_shift #(.DW(DW)) u_piso (
    .clk     (clk),
    .rst_n   (reset),
    .load_i  (load),
    .data_i  (data_in),
    .shift_i (shift),
    .msb_o   (msb)
  );

  // State and counter registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      par_q   <= par_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; done_d flags the transition into IDLE of a completed frame.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    par_d   = par_q;
    done_d  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          load    = 1'b1;
          par_d   = ^data_in;
          baud_d  = '0;
          bit_d   = CW'(DW - 1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (baud_tc) begin
          baud_d = '0;
          shift  = 1'b1;
          if (bit_q == '0) begin
            if (PARITY_EN != 0)   state_d = ST_PARITY;
            else if (GAP_CYC > 0) state_d = ST_GAP;
            else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            bit_d = bit_q - CW'(1);
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_PARITY: begin
        if (baud_tc) begin
          baud_d = '0;
          if (GAP_CYC > 0) state_d = ST_GAP;
          else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP_CYC - 1)) begin
          gap_d   = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Cancelling a frame drops all progress and never reports completion.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      baud_d  = '0;
      bit_d   = '0;
      gap_d   = '0;
      done_d  = 1'b0;
      shift   = 1'b0;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign frame_done = done_q;
  // Line is low outside data/parity and while an abort is being requested.
  assign sout = !abort && (((state_q == ST_SHIFT) && msb) ||
                           ((state_q == ST_PARITY) && par_q));

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Bench for serial_tx_ctrl: frame-level queue model, vector table,
// directed abort/reset/back-to-back sequences and random traffic.
module tb_serial_tx_ctrl;
  localparam int DW = 8, B = 2, P = 1, G = 3;

  logic clk = 1'b0;
  logic reset, dv, ab, dr, so, bz, fd;
  logic [DW-1:0] din;
  logic dv2, ab2, dr2, so2, bz2, fd2;
  logic [DW-1:0] din2;

  int checks = 0, failures = 0;
  bit mq[$];
  bit mdone = 0;
  logic obs_so, obs_bz, obs_rdy, obs_fd;

  always #5 clk = ~clk;

  serial_tx_ctrl #(.DW(DW), .BAUD_DIV(B), .PARITY_EN(P), .GAP_CYC(G)) dut (
    .clk(clk), .reset(reset), .data_in(din), .data_valid(dv), .data_ready(dr),
    .abort(ab), .sout(so), .busy(bz), .frame_done(fd));

  serial_tx_ctrl #(.DW(DW), .BAUD_DIV(B), .PARITY_EN(0), .GAP_CYC(0)) dut2 (
    .clk(clk), .reset(reset), .data_in(din2), .data_valid(dv2), .data_ready(dr2),
    .abort(ab2), .sout(so2), .busy(bz2), .frame_done(fd2));

  typedef struct {
    logic [DW-1:0] data;
    logic          par;
    int            lat;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected line activity of a whole frame, one entry per busy cycle.
  function automatic void build(input logic [DW-1:0] d);
    for (int i = DW - 1; i >= 0; i--) repeat (B) mq.push_back(d[i]);
    if (P != 0) repeat (B) mq.push_back(bit'($countones(d) % 2));
    repeat (G) mq.push_back(1'b0);
  endfunction

  // One clock cycle with the inputs currently driven; checks, then advances the model.
  task automatic step();
    bit mb, ms, mr;
    #1;
    mb = (mq.size() > 0);
    ms = mb ? (!ab && mq[0]) : 1'b0;
    mr = !mb && !ab;
    obs_so = so; obs_bz = bz; obs_rdy = dr; obs_fd = fd;
    chk("sout", so, ms);
    chk("busy", bz, mb);
    chk("data_ready", dr, mr);
    chk("frame_done", fd, mdone);
    @(posedge clk);
    if (mb) begin
      if (ab) begin
        mq.delete();
        mdone = 0;
      end else begin
        void'(mq.pop_front());
        mdone = (mq.size() == 0);
      end
    end else begin
      mdone = 0;
      if (dv && mr) build(din);
    end
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    din = v.data; dv = 1'b1;
    step();
    dv = 1'b0; din = DW'($urandom);
    n = 0;
    do begin
      step();
      n++;
      if (n == DW * B + 1 || n == DW * B + 2) chk("parity_bit", obs_so, v.par);
    end while (!obs_fd && n < 60);
    chk("latency", n, v.lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    tbl[0] = '{8'hA5, 1'b0, 22};
    tbl[1] = '{8'h01, 1'b1, 22};
    tbl[2] = '{8'hFF, 1'b0, 22};
    tbl[3] = '{8'h00, 1'b0, 22};
    tbl[4] = '{8'h80, 1'b1, 22};
    tbl[5] = '{8'h7F, 1'b1, 22};

    dv = 0; ab = 0; din = '0; dv2 = 0; ab2 = 0; din2 = '0;
    reset = 1'b0;
    #1;
    chk("rst_sout", so, 0);
    chk("rst_busy", bz, 0);
    chk("rst_frame_done", fd, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Vector table: data bits via model, parity and latency explicitly.
    foreach (tbl[i]) run_vec(tbl[i]);

    // Back-to-back with data_valid held: second word taken in the frame_done cycle.
    din = 8'h80; dv = 1'b1;
    step();
    din = 8'h01;
    n = 0;
    do begin
      step();
      n++;
      if (n == 18) chk("b2b_parity", obs_so, 1);
      if (n >= 19 && n <= 21) begin
        chk("b2b_gap_sout", obs_so, 0);
        chk("b2b_gap_busy", obs_bz, 1);
      end
    end while (!obs_fd && n < 60);
    chk("b2b_lat1", n, 22);
    chk("b2b_ready_at_done", obs_rdy, 1);
    dv = 1'b0;
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) chk("b2b_first_bit", obs_bz, 1);
    end while (!obs_fd && n < 60);
    chk("b2b_lat2", n, 22);

    // Abort at cycle 5 of an all-ones frame.
    din = 8'hFF; dv = 1'b1;
    step();
    dv = 1'b0;
    repeat (4) step();
    ab = 1'b1;
    step();
    ab = 1'b0;
    step();
    chk("abort_busy", obs_bz, 0);
    chk("abort_ready", obs_rdy, 1);
    chk("abort_sout", obs_so, 0);
    repeat (25) step();

    // Abort together with data_valid in IDLE must not start a frame.
    ab = 1'b1; dv = 1'b1; din = 8'h55;
    step();
    ab = 1'b0; dv = 1'b0;
    step();
    chk("abort_idle_busy", obs_bz, 0);

    // Reset in the middle of a frame.
    din = 8'hC3; dv = 1'b1;
    step();
    dv = 1'b0;
    repeat (8) step();
    reset = 1'b0;
    #1;
    chk("midrst_sout", so, 0);
    chk("midrst_busy", bz, 0);
    chk("midrst_frame_done", fd, 0);
    chk("midrst_baud", dut.baud_q, 0);
    chk("midrst_bitcnt", dut.bit_q, 0);
    mq.delete(); mdone = 0;
    @(negedge clk);
    reset = 1'b1;
    run_vec('{8'h3C, 1'b0, 22});

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      dv  = ($urandom_range(0, 2) == 0);
      ab  = ($urandom_range(0, 49) == 0);
      din = DW'($urandom);
      step();
    end
    ab = 1'b0; dv = 1'b0;
    for (int c = 0; c < 40; c++) step();

    // No parity, no gap: 16 data cycles, frame_done 17 cycles after the handshake.
    din2 = 8'h5A; dv2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dv2 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      logic [DW-1:0] w;
      w = 8'h5A;
      #1;
      if (k <= 16) chk("np_sout", so2, w[DW - 1 - (k - 1) / B]);
      else chk("np_sout_idle", so2, 0);
      chk("np_busy", bz2, (k <= 16));
      chk("np_frame_done", fd2, (k == 17));
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_tx_ctrl.md
SERIAL_TX_CTRL -- requirements
Module: serial_tx_ctrl

Interface
REQ-001 Parameter DW, default 8, data word width in bits (DW >= 2).
REQ-002 Parameter BAUD_DIV, default 4, clock cycles each serial bit is held (BAUD_DIV >= 1).
REQ-003 Parameter PARITY_EN, default 1, 1 appends an even-parity bit after the data bits.
REQ-004 Parameter GAP_CYC, default 2, idle clock cycles forced between frames (GAP_CYC >= 0).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-low.
REQ-007 data_in  input  DW  word to transmit, sampled on handshake.
REQ-008 data_valid  input  1  requester has a word on data_in.
REQ-009 data_ready  output  1  controller accepts a word this cycle.
REQ-010 abort  input  1  synchronous frame cancel.
REQ-011 sout  output  1  serial output, MSB first.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 frame_done  output  1  one-cycle pulse on normal frame completion.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT, PARITY, GAP.
REQ-015 data_ready SHALL be 1 only in IDLE with abort low.
REQ-016 Handshake: data_valid && data_ready at a rising edge SHALL load data_in into the shift register, capture its even parity (XOR of all bits), and enter SHIFT.
REQ-017 data_valid without data_ready SHALL be ignored; data_in need not be held after the handshake.
REQ-018 SHIFT: sout SHALL equal the shift-register MSB; the first data bit appears the cycle after the handshake.
REQ-019 A baud counter SHALL count 0..BAUD_DIV-1; on terminal count the register shifts left by one (zero fill) and the bit counter decrements from DW-1.
REQ-020 After bit 0 completes BAUD_DIV cycles: PARITY if PARITY_EN=1, else GAP if GAP_CYC>0, else IDLE.
REQ-021 PARITY: sout SHALL equal the captured parity bit for BAUD_DIV cycles, then GAP (or IDLE if GAP_CYC=0).
REQ-022 GAP: sout SHALL be 0 for exactly GAP_CYC cycles, then IDLE.
REQ-023 frame_done SHALL pulse for one cycle in the first IDLE cycle after a completed frame, coincident with data_ready=1.
REQ-024 Handshake-to-frame_done latency SHALL be DW*BAUD_DIV + PARITY_EN*BAUD_DIV + GAP_CYC + 1 cycles.
REQ-025 sout SHALL be 0 in IDLE and GAP.
REQ-026 A new handshake MAY occur in the frame_done cycle; back-to-back frames SHALL be separated by exactly GAP_CYC zero cycles.
REQ-027 abort high in any non-IDLE state SHALL return the FSM to IDLE at the next edge, clear the counters, force sout=0, and suppress frame_done.
REQ-028 abort together with data_valid in IDLE SHALL win: no word is accepted.

Reset
REQ-029 reset low SHALL immediately force state IDLE, shift register 0, parity 0, baud and bit counters 0.
REQ-030 During and after reset: sout=0, busy=0, frame_done=0; data_ready=1 from the first edge after reset release.
REQ-031 Reset asserted mid-frame SHALL discard the frame with no frame_done.

Structure
REQ-032 Package serial_tx_pkg SHALL hold the state encoding (2-bit: IDLE=0, SHIFT=1, PARITY=2, GAP=3) and the default parameter constants.
REQ-033 The datapath SHALL be one sub-module, piso_shift (DW-bit parallel-load, shift-enable, MSB serial out, active-low async reset), instantiated once.
REQ-034 Counter widths SHALL be $clog2 of their range, minimum 1 bit.

Verification (DW=8, BAUD_DIV=2, PARITY_EN=1, GAP_CYC=3)
REQ-035 Send 0xA5 -> sout holds 1,0,1,0,0,1,0,1 for 2 cycles each, parity 0 for 2 cycles, 0 for 3 cycles; frame_done 22 cycles after the handshake.
REQ-036 Send 0x01 -> parity bit 1; send 0x80 and 0x01 back-to-back with data_valid held -> second word accepted in the frame_done cycle; exactly 3 zero cycles between frames.
REQ-037 abort at cycle 5 of the 0xFF frame -> IDLE next cycle, sout=0, no frame_done, data_ready=1.
REQ-038 reset low at cycle 9 of the 0xC3 frame -> sout, busy and counters 0 immediately; after release, 0x3C transmits correctly.
REQ-039 abort and data_valid high together in IDLE -> no handshake, busy stays 0.
REQ-040 PARITY_EN=0, GAP_CYC=0, 0x5A -> 16 data cycles, frame_done 17 cycles after the handshake.
